// File: rtl/synapse_bank_if.sv
// synapse_bank_if
// Groups the fill, read and update channels of the synapse weight bank.
//   kill                   : return the bank to the unloaded state
//   load_en/load_data      : sequential table-fill strobe and packed word
//   loaded                 : table full, reads and updates allowed
//   rd_en/rd_addr/rd_ready : weight read request and acceptance
//   rd_valid/weight_out/rd_err : read result, two cycles after acceptance
//   upd_en/upd_addr/upd_delta  : STDP update request (delta is two's complement)
//   upd_busy               : update engine is working on a request
// The master modport is the requester side, the slave modport is the bank.
interface synapse_bank_if #(
  parameter int WW  = 8,
  parameter int WPW = 4,
  parameter int AW  = 16
);
  logic              kill;
  logic              load_en;
  logic [WW*WPW-1:0] load_data;
  logic              loaded;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [WW-1:0]     weight_out;
  logic              rd_err;
  logic              upd_en;
  logic [AW-1:0]     upd_addr;
  logic [WW-1:0]     upd_delta;
  logic              upd_busy;

  modport master (
    output kill, load_en, load_data, rd_en, rd_addr, upd_en, upd_addr, upd_delta,
    input  loaded, rd_ready, rd_valid, weight_out, rd_err, upd_busy
  );

  modport slave (
    input  kill, load_en, load_data, rd_en, rd_addr, upd_en, upd_addr, upd_delta,
    output loaded, rd_ready, rd_valid, weight_out, rd_err, upd_busy
  );
endinterface

// File: rtl/synapse_bank.sv
// synapse_bank
// Table of DEPTH words, each packing WPW weights of WW bits. The table is
// filled sequentially, then serves pipelined weight reads (result two cycles
// after acceptance) and read-modify-write STDP updates with unsigned
// saturation of the target weight.
//   clk : single clock, rising edge
//   rst : synchronous, active-low reset (table contents are kept)
//   bus : synapse_bank_if slave modport carrying all fill/read/update signals
module synapse_bank #(
  parameter int WW    = 8,
  parameter int WPW   = 4,
  parameter int DEPTH = 32,
  parameter int AW    = 16
) (
  input logic           clk,
  input logic           rst,
  synapse_bank_if.slave bus
);
  localparam int DW = WW * WPW;
  localparam int IW = $clog2(DEPTH);
  localparam int LW = (WPW > 1) ? $clog2(WPW) : 1;
  localparam logic [AW-1:0] WPW_A = AW'(WPW);

  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_RD,
    UPD_WR
  } upd_state_e;

  logic [DW-1:0] table_mem [DEPTH];

  upd_state_e    upd_state_q, upd_state_d;
  logic          loaded_q, loaded_d;
  logic [IW-1:0] load_cnt_q, load_cnt_d;
  logic [IW-1:0] upd_idx_q, upd_idx_d;
  logic [LW-1:0] upd_lane_q, upd_lane_d;
  logic [WW-1:0] upd_delta_q, upd_delta_d;
  logic          upd_err_q, upd_err_d;
  logic [DW-1:0] upd_word_q, upd_word_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_err_q, s1_err_d;
  logic [LW-1:0] s1_lane_q, s1_lane_d;
  logic [DW-1:0] s1_word_q, s1_word_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;
  logic [WW-1:0] weight_out_q, weight_out_d;

  logic [AW-1:0] rd_word, upd_word;
  logic          rd_oor, upd_oor, rd_ready, rd_accept;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [WW-1:0] old_lane, new_lane;
  logic [WW+1:0] sat_sum;

  // Address split into table word and lane within the word.
  assign rd_word  = bus.rd_addr / WPW_A;
  assign upd_word = bus.upd_addr / WPW_A;
  assign rd_oor   = 32'(rd_word) >= 32'(DEPTH);
  assign upd_oor  = 32'(upd_word) >= 32'(DEPTH);

  // Reads are only taken when no update is pending or starting, so a read
  // never overlaps the read-modify-write of the update engine.
  assign rd_ready  = loaded_q && (upd_state_q == UPD_IDLE) && !bus.upd_en && !bus.kill;
  assign rd_accept = bus.rd_en && rd_ready;

  // Saturating lane arithmetic: two guard bits catch both underflow (sign)
  // and overflow (carry) of old + sext(delta).
  assign old_lane = upd_word_q[upd_lane_q*WW +: WW];
  assign sat_sum  = {2'b00, old_lane} + {{2{upd_delta_q[WW-1]}}, upd_delta_q};
  always_comb begin
    new_lane = sat_sum[WW-1:0];
    if (sat_sum[WW+1]) begin
      new_lane = '0;
    end else if (sat_sum[WW]) begin
      new_lane = '1;
    end
  end

  // Next-state logic for fill counter, read pipeline and update FSM, plus
  // the single table write port shared by fill and update write-back.
  always_comb begin
    upd_state_d  = upd_state_q;
    loaded_d     = loaded_q;
    load_cnt_d   = load_cnt_q;
    upd_idx_d    = upd_idx_q;
    upd_lane_d   = upd_lane_q;
    upd_delta_d  = upd_delta_q;
    upd_err_d    = upd_err_q;
    upd_word_d   = upd_word_q;
    mem_we       = 1'b0;
    mem_waddr    = upd_idx_q;
    mem_wdata    = upd_word_q;

    if (!loaded_q && bus.load_en) begin
      mem_we    = 1'b1;
      mem_waddr = load_cnt_q;
      mem_wdata = bus.load_data;
      if (load_cnt_q == IW'(DEPTH - 1)) begin
        loaded_d   = 1'b1;
        load_cnt_d = '0;
      end else begin
        load_cnt_d = load_cnt_q + 1'b1;
      end
    end

    s1_valid_d = rd_accept;
    s1_err_d   = rd_oor;
    s1_lane_d  = LW'(bus.rd_addr % WPW_A);
    s1_word_d  = '0;
    if (rd_accept && !rd_oor) begin
      s1_word_d = table_mem[IW'(rd_word)];
    end

    rd_valid_d   = s1_valid_q;
    rd_err_d     = s1_valid_q && s1_err_q;
    weight_out_d = '0;
    if (s1_valid_q && !s1_err_q) begin
      weight_out_d = s1_word_q[s1_lane_q*WW +: WW];
    end

    case (upd_state_q)
      UPD_IDLE: begin
        if (bus.upd_en && loaded_q) begin
          upd_state_d = UPD_RD;
          upd_idx_d   = IW'(upd_word);
          upd_lane_d  = LW'(bus.upd_addr % WPW_A);
          upd_delta_d = bus.upd_delta;
          upd_err_d   = upd_oor;
        end
      end
      UPD_RD: begin
        if (!upd_err_q) begin
          upd_word_d = table_mem[upd_idx_q];
        end
        upd_state_d = UPD_WR;
      end
      UPD_WR: begin
        if (!upd_err_q) begin
          mem_we    = 1'b1;
          mem_waddr = upd_idx_q;
          mem_wdata = upd_word_q;
          mem_wdata[upd_lane_q*WW +: WW] = new_lane;
        end
        upd_state_d = UPD_IDLE;
      end
      default: upd_state_d = UPD_IDLE;
    endcase

    // kill drops back to unloaded without touching the table
    if (bus.kill) begin
      loaded_d    = 1'b0;
      load_cnt_d  = '0;
      upd_state_d = UPD_IDLE;
      mem_we      = 1'b0;
    end
  end

  // Control and pipeline registers; reset leaves the table alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_state_q  <= UPD_IDLE;
      loaded_q     <= 1'b0;
      load_cnt_q   <= '0;
      upd_idx_q    <= '0;
      upd_lane_q   <= '0;
      upd_delta_q  <= '0;
      upd_err_q    <= 1'b0;
      upd_word_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_lane_q    <= '0;
      s1_word_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      weight_out_q <= '0;
    end else begin
      upd_state_q  <= upd_state_d;
      loaded_q     <= loaded_d;
      load_cnt_q   <= load_cnt_d;
      upd_idx_q    <= upd_idx_d;
      upd_lane_q   <= upd_lane_d;
      upd_delta_q  <= upd_delta_d;
      upd_err_q    <= upd_err_d;
      upd_word_q   <= upd_word_d;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s1_lane_q    <= s1_lane_d;
      s1_word_q    <= s1_word_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
      weight_out_q <= weight_out_d;
    end
  end

  // Table write port; a reset edge suppresses any write, aborting an update.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      table_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.loaded     = loaded_q;
  assign bus.rd_ready   = rd_ready;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.weight_out = weight_out_q;
  assign bus.upd_busy   = (upd_state_q != UPD_IDLE);
endmodule

// File: tb/tb_synapse_bank.sv
// tb_synapse_bank
// Self-checking bench for synapse_bank with default parameters. A flat
// array of 128 weights is the reference model; reads push expected results
// into a queue that a monitor compares against rd_valid/rd_err/weight_out.
module tb_synapse_bank;
  localparam int NW = 128;

  typedef struct {
    logic       err;
    logic [7:0] w;
  } exp_t;

  logic clk;
  logic rst;

  synapse_bank_if #(.WW(8), .WPW(4), .AW(16)) bus ();

  synapse_bank #(.WW(8), .WPW(4), .DEPTH(32), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] weights [NW];
  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         failures = 0;
  bit         mon_on = 0;
  int         run_cnt = 0;
  int         last_run = 0;
  int         busy_m;
  bit         pend;
  int         pend_addr;
  bit         do_upd;
  logic [7:0] w;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit upd, input int uaddr, input logic [7:0] delta,
                               input bit rd, input int raddr);
    bus.upd_en    = upd;
    bus.upd_addr  = 16'(uaddr);
    bus.upd_delta = delta;
    bus.rd_en     = rd;
    bus.rd_addr   = 16'(raddr);
  endtask

  task automatic applyModelUpdate(input int addr, input logic [7:0] delta);
    int s;
    if (addr < NW) begin
      s = int'(weights[addr]) + int'($signed(delta));
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      weights[addr] = 8'(s);
    end
  endtask

  task automatic pushExpected(input int addr);
    exp_t x;
    if (addr >= NW) begin
      x.err = 1'b1;
      x.w   = 8'h00;
    end else begin
      x.err = 1'b0;
      x.w   = weights[addr];
    end
    exp_q.push_back(x);
  endtask

  // Fills all 32 words, with random pauses; either the counting pattern
  // (which also defines the model) or the current model contents.
  task automatic fillTable(input bit use_pattern);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] word;
      word = '0;
      if (use_pattern) begin
        word = 32'h03020100 + 32'h04040404 * i;
        for (int k = 0; k < 4; k++) weights[4*i+k] = word[8*k +: 8];
      end else begin
        for (int k = 0; k < 4; k++) word[8*k +: 8] = weights[4*i+k];
      end
      bus.load_en = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.load_en   = 1'b1;
      bus.load_data = word;
      @(negedge clk);
      checkOutput("loaded_fill", bus.loaded, (i == 31) ? 1 : 0);
    end
    bus.load_en = 1'b0;
  endtask

  // Holds a read request until accepted; returns at the negedge after.
  task automatic issueRead(input int addr);
    bit done = 0;
    applyStimulus(0, 0, 8'h00, 1, addr);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.rd_ready) begin
        pushExpected(addr);
        done = 1;
      end
      @(negedge clk);
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    if (!done) checkOutput("rd_ready_timeout", 0, 1);
  endtask

  task automatic readWeight(input int addr, output logic [7:0] wv);
    bit got = 0;
    wv = 8'hxx;
    issueRead(addr);
    for (int i = 0; i < 4 && !got; i++) begin
      if (bus.rd_valid === 1'b1) begin
        wv  = bus.weight_out;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) checkOutput("rd_valid_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic doUpdate(input int addr, input logic [7:0] delta);
    applyStimulus(1, addr, delta, 0, 0);
    #1;
    checkOutput("upd_blocks_rd", bus.rd_ready, 0);
    applyModelUpdate(addr, delta);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("upd_busy_rd", bus.upd_busy, 1);
    @(negedge clk);
    checkOutput("upd_busy_wr", bus.upd_busy, 1);
    @(negedge clk);
    checkOutput("upd_idle", bus.upd_busy, 0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Read-result monitor: every valid pulse must match the oldest expected
  // result, and weight_out must be zero between pulses.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.rd_valid === 1'b1) begin
        run_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("rd_valid_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rd_err", bus.rd_err, e.err);
          checkOutput("weight_out", bus.weight_out, e.w);
        end
      end else begin
        if (run_cnt > 0) begin
          last_run = run_cnt;
          run_cnt  = 0;
        end
        checkOutput("weight_idle", bus.weight_out, 0);
      end
    end
  end

  initial begin
    rst           = 1'b0;
    bus.kill      = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_data = '0;
    applyStimulus(0, 0, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_loaded", bus.loaded, 0);
    checkOutput("rst_busy", bus.upd_busy, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_rd_err", bus.rd_err, 0);
    checkOutput("rst_weight", bus.weight_out, 0);
    checkOutput("rst_rd_ready", bus.rd_ready, 0);
    rst    = 1'b1;
    mon_on = 1;
    @(negedge clk);

    // partial fill, then kill while load_en is still asserted at word 10
    for (int i = 0; i < 10; i++) begin
      bus.load_en   = 1'b1;
      bus.load_data = 32'hDEADBEEF ^ 32'(i);
      @(negedge clk);
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill    = 1'b0;
    bus.load_en = 1'b0;
    checkOutput("kill_loaded", bus.loaded, 0);
    checkOutput("kill_rd_ready", bus.rd_ready, 0);

    // refill must restart at word 0 and finish after exactly 32 writes
    fillTable(1);

    // load_en is ignored once loaded
    bus.load_en   = 1'b1;
    bus.load_data = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    bus.load_en = 1'b0;
    checkOutput("loaded_hold", bus.loaded, 1);

    // single read of addr 5 with exact latency
    applyStimulus(0, 0, 8'h00, 1, 5);
    #1;
    checkOutput("rd_ready_idle", bus.rd_ready, 1);
    if (bus.rd_ready) pushExpected(5);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("lat_t1_valid", bus.rd_valid, 0);
    @(negedge clk);
    checkOutput("lat_t2_valid", bus.rd_valid, 1);
    checkOutput("fill_addr5", bus.weight_out, 8'h05);
    @(negedge clk);
    checkOutput("lat_t3_valid", bus.rd_valid, 0);
    waitDrain();

    // back-to-back reads of 0..128
    for (int a = 0; a <= 128; a++) begin
      applyStimulus(0, 0, 8'h00, 1, a);
      #1;
      checkOutput("pipe_rd_ready", bus.rd_ready, 1);
      if (bus.rd_ready) pushExpected(a);
      @(negedge clk);
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    waitDrain();
    checkOutput("pipe_run_len", last_run, 129);

    // saturation high on addr 17
    repeat (3) doUpdate(17, 8'd127);
    doUpdate(17, 8'hF1);
    readWeight(17, w);
    checkOutput("sat_pre_hi", w, 8'hF0);
    doUpdate(17, 8'h20);
    readWeight(17, w);
    checkOutput("sat_hi", w, 8'hFF);

    // saturation low on addr 18
    repeat (3) doUpdate(18, 8'h80);
    doUpdate(18, 8'h05);
    readWeight(18, w);
    checkOutput("sat_pre_lo", w, 8'h05);
    doUpdate(18, 8'hF0);
    readWeight(18, w);
    checkOutput("sat_lo", w, 8'h00);
    readWeight(16, w);
    checkOutput("lane_keep_16", w, 8'd16);
    readWeight(19, w);
    checkOutput("lane_keep_19", w, 8'd19);
    waitDrain();

    // update and read collide; read retried once the engine is idle
    applyStimulus(1, 40, 8'h03, 1, 40);
    #1;
    checkOutput("coll_rd_ready", bus.rd_ready, 0);
    applyModelUpdate(40, 8'h03);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 1, 40);
    #1;
    checkOutput("coll_busy1", bus.upd_busy, 1);
    checkOutput("coll_rd_ready1", bus.rd_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("coll_busy2", bus.upd_busy, 1);
    checkOutput("coll_rd_ready2", bus.rd_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("coll_busy3", bus.upd_busy, 0);
    checkOutput("coll_rd_ready3", bus.rd_ready, 1);
    if (bus.rd_ready) pushExpected(40);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    checkOutput("coll_valid", bus.rd_valid, 1);
    checkOutput("coll_updated", bus.weight_out, 8'd43);
    waitDrain();

    // randomized mix of reads and updates, including out-of-range addresses
    busy_m = 0;
    pend   = 0;
    for (int c = 0; c < 400; c++) begin
      checkOutput("rnd_upd_busy", bus.upd_busy, (busy_m > 0) ? 1 : 0);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend      = 1;
        pend_addr = $urandom_range(0, 139);
      end
      do_upd = ($urandom_range(0, 4) == 0);
      applyStimulus(do_upd, $urandom_range(0, 139), 8'($urandom), pend, pend_addr);
      #1;
      checkOutput("rnd_rd_ready", bus.rd_ready, (busy_m == 0 && !do_upd) ? 1 : 0);
      if (pend && bus.rd_ready) begin
        pushExpected(pend_addr);
        pend = 0;
      end
      if (do_upd && busy_m == 0) begin
        applyModelUpdate(int'(bus.upd_addr), bus.upd_delta);
        busy_m = 2;
      end else if (busy_m > 0) begin
        busy_m--;
      end
      @(negedge clk);
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    waitDrain();

    // reset during the write-back cycle: no write, bank unloaded
    applyStimulus(1, 60, 8'h01, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("rstwr_busy_rd", bus.upd_busy, 1);
    @(negedge clk);
    checkOutput("rstwr_busy_wr", bus.upd_busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rstwr_loaded", bus.loaded, 0);
    checkOutput("rstwr_busy", bus.upd_busy, 0);
    checkOutput("rstwr_rd_valid", bus.rd_valid, 0);
    checkOutput("rstwr_rd_err", bus.rd_err, 0);
    fillTable(0);
    readWeight(60, w);
    checkOutput("rstwr_old", w, weights[60]);
    waitDrain();

    // reset flushes a read in flight
    applyStimulus(0, 0, 8'h00, 1, 7);
    #1;
    checkOutput("flush_rd_ready", bus.rd_ready, 1);
    @(negedge clk);
    applyStimulus(0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("flush_rd_valid", bus.rd_valid, 0);
    checkOutput("flush_loaded", bus.loaded, 0);
    @(negedge clk);
    checkOutput("flush_rd_valid2", bus.rd_valid, 0);
    fillTable(0);
    readWeight(7, w);
    checkOutput("flush_refill_7", w, weights[7]);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/synapse_bank.md
SYNAPSE_BANK -- requirements
Module: synapse_bank

Interface
REQ-001 SHALL have parameter WW, default 8, meaning weight width in bits.
REQ-002 SHALL have parameter WPW, default 4, meaning weights packed per table word; word width is WW*WPW.
REQ-003 SHALL have parameter DEPTH, default 32, meaning table words; must be a power of two and at least 2.
REQ-004 SHALL have parameter AW, default 16, meaning weight address width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous and active-low.
REQ-007 SHALL have port kill, input, 1, meaning return to the unloaded state; table contents are kept.
REQ-008 SHALL have ports load_en (input, 1) and load_data (input, WW*WPW), meaning the sequential table-fill strobe and data.
REQ-009 SHALL have port loaded, output, 1, meaning the table is full and reads and updates are allowed.
REQ-010 SHALL have ports rd_en (input, 1) and rd_addr (input, AW), meaning a weight read request.
REQ-011 SHALL have port rd_ready, output, 1, meaning a read is accepted this cycle.
REQ-012 SHALL have ports rd_valid (output, 1), weight_out (output, WW) and rd_err (output, 1), meaning the read result.
REQ-013 SHALL have ports upd_en (input, 1), upd_addr (input, AW) and upd_delta (input, WW, two's complement), meaning an STDP update request.
REQ-014 SHALL have port upd_busy, output, 1, meaning the update FSM is not IDLE.

Function
REQ-015 SHALL decode any address as: word = addr / WPW, lane = addr % WPW; lane 0 is bits [WW-1:0].
REQ-016 SHALL treat an address as out of range when word >= DEPTH.
REQ-017 SHALL fill the table while loaded=0: each cycle with load_en=1 writes load_data to table[load_cnt], then increments load_cnt.
REQ-018 SHALL set loaded=1 on the cycle after the write to word DEPTH-1; load_cnt then holds at 0.
REQ-019 SHALL ignore load_en while loaded=1.
REQ-020 SHALL, while loaded=0 and load_en=0, hold load_cnt, so the fill may pause between words.
REQ-021 SHALL, when kill=1, clear loaded and load_cnt and force the update FSM to IDLE next cycle, without writing the table; kill overrides load_en.
REQ-022 SHALL drive rd_ready = loaded AND FSM IDLE AND NOT upd_en AND NOT kill (combinational); a read is accepted when rd_en AND rd_ready.
REQ-023 SHALL drop rd_en without effect when not accepted; the requester holds the request until rd_ready.
REQ-024 SHALL give an accepted read at cycle t a registered table-word fetch at t+1, then a one-cycle rd_valid pulse at t+2.
REQ-025 SHALL drive weight_out at t+2 with the lane selected per REQ-015 for an in-range read.
REQ-026 SHALL, for an out-of-range read, drive weight_out=0 and rd_err=1 together with rd_valid, with no table access.
REQ-027 SHALL support fully pipelined reads: one read accepted per cycle gives rd_valid high on consecutive cycles.
REQ-028 SHALL give weight_out zero whenever rd_valid=0.
REQ-029 SHALL run the update FSM IDLE -> RD -> WR -> IDLE.
REQ-030 SHALL leave IDLE when upd_en=1, loaded=1 and kill=0, capturing upd_addr and upd_delta; upd_en has priority over rd_en in the same cycle.
REQ-031 SHALL, in state RD, register the target word.
REQ-032 SHALL, in state WR, write back the word with only the target lane changed: new = clamp(old + sext(delta), 0, 2^WW-1), computed in WW+2 bits, unsigned saturating.
REQ-033 SHALL ignore upd_en outside IDLE.
REQ-034 SHALL silently discard an out-of-range update: it passes through RD and WR with no write.
REQ-035 SHALL ensure a read accepted after an update write cycle returns the updated value, and a read in flight when an update starts returns the pre-update value.

Reset
REQ-036 SHALL, on rst=0 at a clock edge, set loaded=0, load_cnt=0, FSM=IDLE, rd_valid=0, rd_err=0, weight_out=0 and clear the read pipeline.
REQ-037 SHALL leave table contents unchanged by reset; reset has priority over kill and all requests.
REQ-038 SHALL abort a reset mid-update with no write.

Verification
REQ-039 SHALL verify the fill: 32 words 0x03020100+0x04040404*i with default parameters -> loaded=1 one cycle after the 32nd write; read addr 5 -> weight_out=0x05 at t+2.
REQ-040 SHALL verify pipelined reads: back-to-back addresses 0..127 -> 128 consecutive rd_valid pulses with weight_out==addr; addr 128 -> rd_err=1, weight_out=0.
REQ-041 SHALL verify saturation: weight 0xF0, delta +0x20 -> 0xFF; weight 0x05, delta 0xF0 (-16) -> 0x00; other lanes of the word unchanged.
REQ-042 SHALL verify the collision: upd_en and rd_en in the same cycle -> rd_ready=0, upd_busy=1 for 2 cycles; a read retried after IDLE returns the updated weight.
REQ-043 SHALL verify kill and reset: kill mid-fill at word 10 -> loaded=0, load_cnt=0, and refill restarts at word 0; rst=0 during WR -> no write, and a later read returns the old value.
